rca_operand_loader: RTL

//  Upstream/downstream sequencing stage for the ripple-carry adder. Captures operand A, then

---
 rtl/rca_pkg.sv | 14 +
 rtl/rise_detect.sv | 18 +
 rtl/rca_operand_loader.sv | 112 +++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared types and helpers for the ripple-carry adder operand loader.
package rca_pkg;

    typedef enum logic [1:0] {IDLE, GOT_A, SETTLE, DONE} loader_state_t;

    // The settle counter is 4 bits wide, so this is the longest wait it can time.
    localparam int SETTLE_MAX = 15;

    // Two's-complement overflow: operands share a sign that the sum does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-cycle pulse on a rising level; history resets high so a level held through reset never fires.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic pulse_o
);

    logic lvl_q;

    always_ff @(posedge clk) begin
        if (rst) lvl_q <= 1'b1;
        else     lvl_q <= lvl_i;
    end

    assign pulse_o = lvl_i & ~lvl_q;

endmodule

// File: rtl/rca_operand_loader.sv
// Sequences switch operands into an external ripple-carry adder and registers its settled result.
module rca_operand_loader
    import rca_pkg::*;
#(
    parameter int BITS          = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] sw_i,
    input  logic            cin_i,
    input  logic            load_a_i,
    input  logic            load_b_i,
    output logic [BITS-1:0] a_o,
    output logic [BITS-1:0] b_o,
    output logic            cin_o,
    input  logic [BITS-1:0] sum_i,
    input  logic            cout_i,
    output logic [BITS-1:0] result_o,
    output logic            cout_o,
    output logic            ovf_o,
    output logic            valid_o,
    output logic            busy_o
);

    // Out-of-range settings are pinned to what the 4-bit counter can express.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 :
                                (SETTLE_CYCLES > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYCLES;
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_EFF - 1);

    loader_state_t state, state_next;
    logic [3:0]    cnt;
    logic          ev_a, ev_b;
    logic          ld_a, ld_b, ld_res;

    rise_detect u_rise_a (.clk(clk), .rst(rst), .lvl_i(load_a_i), .pulse_o(ev_a));
    rise_detect u_rise_b (.clk(clk), .rst(rst), .lvl_i(load_b_i), .pulse_o(ev_b));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        ld_res     = 1'b0;
        case (state)
            IDLE: begin
                if (ev_a) begin
                    ld_a       = 1'b1;
                    state_next = GOT_A;
                end
            end
            GOT_A: begin
                // B wins a same-cycle tie so the pending A is not disturbed.
                if (ev_b) begin
                    ld_b       = 1'b1;
                    state_next = SETTLE;
                end else if (ev_a) begin
                    ld_a = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == CNT_LAST) begin
                    ld_res     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ev_a) begin
                    ld_a       = 1'b1;
                    state_next = GOT_A;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state == SETTLE);
        valid_o = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_o      <= '0;
            b_o      <= '0;
            cin_o    <= 1'b0;
            result_o <= '0;
            cout_o   <= 1'b0;
            ovf_o    <= 1'b0;
            cnt      <= '0;
        end else begin
            if (ld_a) a_o <= sw_i;
            if (ld_b) begin
                b_o   <= sw_i;
                cin_o <= cin_i;
                cnt   <= '0;
            end else if (state == SETTLE) begin
                cnt <= cnt + 4'd1;
            end
            if (ld_res) begin
                result_o <= sum_i;
                cout_o   <= cout_i;
                ovf_o    <= signed_ovf(a_o[BITS-1], b_o[BITS-1], sum_i[BITS-1]);
            end
        end
    end

endmodule
